// File: rtl/allocator_pkg.sv
// Shared allocator types: the free-list header record and the LSU request/response
// structs that carry it.
package allocator_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    LSU_NOP,
    LSU_LOCK,
    LSU_UNLOCK,
    LSU_LOAD,
    LSU_INSERT,
    LSU_DELETE
  } req_lsu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } header_data_t;

  typedef struct packed {
    logic         val;
    req_lsu_op_e  lsu_op;
    header_data_t header_data;
  } header_data_req_t;

  typedef struct packed {
    logic         val;
    header_data_t header_data;
  } header_data_rsp_t;

endpackage

// File: rtl/fit_alloc_calc.sv
// Combinational size alignment and block-split arithmetic for the allocator.
module fit_alloc_calc #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned HEADER_SIZE = 16,
  parameter int unsigned ALIGN_LOG2  = 3,
  parameter int unsigned MIN_SPLIT   = 8
) (
  input  logic [DATA_W-1:0] size,
  input  logic [DATA_W-1:0] c_size,
  input  logic [DATA_W-1:0] c_addr,
  output logic [DATA_W:0]   req_a,
  output logic              overflow,
  output logic              split,
  output logic [DATA_W-1:0] new_addr,
  output logic [DATA_W-1:0] new_size
);

  localparam logic [DATA_W:0]   ALIGN_M = (DATA_W+1)'((1 << ALIGN_LOG2) - 1);
  localparam logic [DATA_W+1:0] SPLIT_X = (DATA_W+2)'(HEADER_SIZE + MIN_SPLIT);

  logic [DATA_W+1:0] need;

  assign req_a    = ({1'b0, size} + ALIGN_M) & ~ALIGN_M;
  assign overflow = req_a[DATA_W];
  // Extra headroom bit so req_a+header+min_split never wraps.
  assign need     = {1'b0, req_a} + SPLIT_X;
  assign split    = !overflow && ({2'b00, c_size} >= need);
  assign new_addr = c_addr + DATA_W'(HEADER_SIZE) + req_a[DATA_W-1:0];
  assign new_size = c_size - req_a[DATA_W-1:0] - DATA_W'(HEADER_SIZE);

endmodule

// File: rtl/fit_alloc_core.sv
// Free-list allocator: locks the list, walks headers through the LSU, splits or
// unlinks the chosen block, unlocks. Define ALLOC_BEST_FIT_EN for best-fit search.
module fit_alloc_core
  import allocator_pkg::*;
#(
  parameter int unsigned       DATA_W      = allocator_pkg::DATA_W,
  parameter int unsigned       HEADER_SIZE = 16,
  parameter int unsigned       ALIGN_LOG2  = 3,
  parameter int unsigned       MIN_SPLIT   = 8,
  parameter logic [DATA_W-1:0] HEAD_ADDR   = 'h10,
  parameter int unsigned       MAX_WALK    = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_alloc_valid_i,
  input  logic [DATA_W-1:0] size_to_allocate_i,
  output logic              core_ready_o,
  output logic              alloc_rsp_valid_o,
  output logic              alloc_rsp_ok_o,
  output logic [DATA_W-1:0] alloc_addr_o,
  input  logic              lsu_ready_i,
  output header_data_req_t  req_to_lsu_o,
  input  header_data_rsp_t  rsp_from_lsu_i
);

  localparam int WALK_W = $clog2(MAX_WALK + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOCK, S_LOCK_W, S_LOAD, S_LOAD_W, S_CMP, S_INSERT, S_INSERT_W,
    S_LINK, S_LINK_W, S_UNLOCK, S_UNLOCK_W, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] size_q, load_addr_q, addr_q;
  logic [WALK_W-1:0] walk_q;
  logic              ok_q;
  header_data_t      cur_q, prev_q, ins_q, link_q;
  header_data_t      pick_hdr, pick_prev;
  header_data_req_t  lsu_req;

  logic [DATA_W-1:0] calc_size, new_addr, new_size;
  logic [DATA_W:0]   req_a;
  logic              overflow, split;
  logic              fit_now, walk_end, have_pick, cmp_done;
  logic [DATA_W-1:0] unused_rsp_addr;

  assign unused_rsp_addr = rsp_from_lsu_i.header_data.addr;
  assign calc_size = (state_q == S_IDLE) ? size_to_allocate_i : size_q;

  fit_alloc_calc #(
    .DATA_W(DATA_W), .HEADER_SIZE(HEADER_SIZE), .ALIGN_LOG2(ALIGN_LOG2), .MIN_SPLIT(MIN_SPLIT)
  ) u_calc (
    .size     (calc_size),
    .c_size   (pick_hdr.size),
    .c_addr   (pick_hdr.addr),
    .req_a    (req_a),
    .overflow (overflow),
    .split    (split),
    .new_addr (new_addr),
    .new_size (new_size)
  );

  // Sentinel has size 0 and is excluded even though req_a is never 0 here.
  assign fit_now  = (cur_q.size != '0) && ({1'b0, cur_q.size} >= req_a);
  assign walk_end = (cur_q.next_addr == '0) || (walk_q == WALK_W'(MAX_WALK));

`ifdef ALLOC_BEST_FIT_EN
  header_data_t best_q, best_prev_q;
  logic         best_vld_q, take_now;

  assign take_now  = fit_now && (!best_vld_q || (cur_q.size < best_q.size));
  assign pick_hdr  = take_now ? cur_q  : best_q;
  assign pick_prev = take_now ? prev_q : best_prev_q;
  assign have_pick = take_now || best_vld_q;
  assign cmp_done  = walk_end;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      best_q      <= '0;
      best_prev_q <= '0;
      best_vld_q  <= 1'b0;
    end else if (state_q == S_IDLE && req_alloc_valid_i) begin
      best_vld_q  <= 1'b0;
    end else if (state_q == S_CMP && take_now) begin
      best_q      <= cur_q;
      best_prev_q <= prev_q;
      best_vld_q  <= 1'b1;
    end
  end
`else
  assign pick_hdr  = cur_q;
  assign pick_prev = prev_q;
  assign have_pick = fit_now;
  assign cmp_done  = fit_now || walk_end;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    lsu_req = '0;
    unique case (state_q)
      S_IDLE:
        if (req_alloc_valid_i)
          state_d = ((size_to_allocate_i == '0) || overflow) ? S_DONE : S_LOCK;
      S_LOCK: begin
        lsu_req.val    = 1'b1;
        lsu_req.lsu_op = LSU_LOCK;
        if (lsu_ready_i) state_d = S_LOCK_W;
      end
      S_LOCK_W:   if (rsp_from_lsu_i.val) state_d = S_LOAD;
      S_LOAD: begin
        lsu_req.val                   = 1'b1;
        lsu_req.lsu_op                = LSU_LOAD;
        lsu_req.header_data.addr      = load_addr_q;
        if (lsu_ready_i) state_d = S_LOAD_W;
      end
      S_LOAD_W:   if (rsp_from_lsu_i.val) state_d = S_CMP;
      S_CMP:
        if (!cmp_done)      state_d = S_LOAD;
        else if (!have_pick) state_d = S_UNLOCK;
        else                state_d = split ? S_INSERT : S_LINK;
      S_INSERT: begin
        lsu_req.val         = 1'b1;
        lsu_req.lsu_op      = LSU_INSERT;
        lsu_req.header_data = ins_q;
        if (lsu_ready_i) state_d = S_INSERT_W;
      end
      S_INSERT_W: if (rsp_from_lsu_i.val) state_d = S_LINK;
      S_LINK: begin
        lsu_req.val         = 1'b1;
        lsu_req.lsu_op      = LSU_DELETE;
        lsu_req.header_data = link_q;
        if (lsu_ready_i) state_d = S_LINK_W;
      end
      S_LINK_W:   if (rsp_from_lsu_i.val) state_d = S_UNLOCK;
      S_UNLOCK: begin
        lsu_req.val    = 1'b1;
        lsu_req.lsu_op = LSU_UNLOCK;
        if (lsu_ready_i) state_d = S_UNLOCK_W;
      end
      S_UNLOCK_W: if (rsp_from_lsu_i.val) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      size_q      <= '0;
      load_addr_q <= '0;
      addr_q      <= '0;
      walk_q      <= '0;
      ok_q        <= 1'b0;
      cur_q       <= '0;
      prev_q      <= '0;
      ins_q       <= '0;
      link_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (req_alloc_valid_i) begin
            size_q <= size_to_allocate_i;
            walk_q <= '0;
            ok_q   <= 1'b0;
            addr_q <= '0;
            cur_q  <= '0;
            prev_q <= '0;
          end
        S_LOCK_W:
          if (rsp_from_lsu_i.val) load_addr_q <= HEAD_ADDR;
        S_LOAD_W:
          if (rsp_from_lsu_i.val) begin
            // Address comes from our own request; the response only supplies size/next.
            cur_q  <= '{addr: load_addr_q,
                        size: rsp_from_lsu_i.header_data.size,
                        next_addr: rsp_from_lsu_i.header_data.next_addr};
            walk_q <= walk_q + 1'b1;
          end
        S_CMP: begin
          prev_q      <= cur_q;
          load_addr_q <= cur_q.next_addr;
          if (cmp_done && have_pick) begin
            ok_q   <= 1'b1;
            addr_q <= pick_hdr.addr + DATA_W'(HEADER_SIZE);
            ins_q  <= '{addr: new_addr, size: new_size, next_addr: pick_hdr.next_addr};
            link_q <= '{addr: pick_prev.addr, size: pick_prev.size,
                        next_addr: split ? new_addr : pick_hdr.next_addr};
          end
        end
        default: ;
      endcase
    end
  end

  assign core_ready_o      = rst_ni && (state_q == S_IDLE);
  assign alloc_rsp_valid_o = (state_q == S_DONE);
  assign alloc_rsp_ok_o    = alloc_rsp_valid_o && ok_q;
  assign alloc_addr_o      = alloc_rsp_valid_o ? addr_q : '0;
  assign req_to_lsu_o      = lsu_req;

endmodule

// File: tb/tb_fit_alloc_core.sv
// Randomized bench for fit_alloc_core: an LSU model serves headers from a list and
// logs requests, compared against a list-walk reference of the allocation rules.
module tb_fit_alloc_core;
  import allocator_pkg::*;

  localparam logic [31:0] HEAD = 32'h10;
`ifdef ALLOC_BEST_FIT_EN
  localparam bit BEST = 1'b1;
`else
  localparam bit BEST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic [31:0]      req_size = '0;
  logic             core_ready, rsp_valid, rsp_ok;
  logic [31:0]      rsp_addr;
  logic             lsu_ready = 1'b0;
  header_data_req_t lsu_req;
  header_data_rsp_t lsu_rsp = '0;

  fit_alloc_core dut (
    .clk_i(clk), .rst_ni(rst_n), .req_alloc_valid_i(req_valid), .size_to_allocate_i(req_size),
    .core_ready_o(core_ready), .alloc_rsp_valid_o(rsp_valid), .alloc_rsp_ok_o(rsp_ok),
    .alloc_addr_o(rsp_addr), .lsu_ready_i(lsu_ready), .req_to_lsu_o(lsu_req),
    .rsp_from_lsu_i(lsu_rsp)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int unsigned msize [int unsigned];
  int unsigned mnext [int unsigned];
  header_data_req_t exp_q[$], got_q[$];
  int  stall_left = 0, unlock_cyc = 0;
  bit  saw_val = 0;
  bit  last_ok;
  logic [31:0] last_addr;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int unsigned msz(input int unsigned a);
    return msize.exists(a) ? msize[a] : 0;
  endfunction
  function automatic int unsigned mnx(input int unsigned a);
    return mnext.exists(a) ? mnext[a] : 0;
  endfunction

  // Free list: sentinel at HEAD, then blocks at 0x100, 0x200, ...
  task automatic build(input int unsigned sizes[$]);
    msize.delete(); mnext.delete();
    msize[HEAD] = 0;
    mnext[HEAD] = (sizes.size() > 0) ? 32'h100 : 0;
    for (int k = 0; k < sizes.size(); k++) begin
      msize[32'h100 * (k + 1)] = sizes[k];
      mnext[32'h100 * (k + 1)] = (k + 1 < sizes.size()) ? 32'h100 * (k + 2) : 0;
    end
  endtask

  task automatic push(input req_lsu_op_e op, input longint unsigned a, input longint unsigned s,
                      input longint unsigned n);
    header_data_req_t e;
    e.val = 1'b1; e.lsu_op = op;
    e.header_data = '{addr: a[31:0], size: s[31:0], next_addr: n[31:0]};
    exp_q.push_back(e);
  endtask

  // Reference: walk the list in plain arithmetic and list the expected LSU traffic.
  task automatic model(input logic [31:0] sz, output bit ok, output logic [31:0] ad);
    longint unsigned ra, cs, bs, na;
    int unsigned a, prv, ca, cprv, walks;
    bit found, stop;
    exp_q.delete(); ok = 0; ad = 0; bs = 0; ca = 0; cprv = 0;
    ra = ((longint'(sz) + 7) / 8) * 8;
    if (sz == 0 || ra > 64'hFFFF_FFFF) return;
    push(LSU_LOCK, 0, 0, 0);
    a = HEAD; prv = 0; walks = 0; found = 0; stop = 0;
    while (!stop) begin
      push(LSU_LOAD, a, 0, 0);
      walks++;
      cs = msz(a);
      if (cs != 0 && cs >= ra && (!found || (BEST && cs < bs))) begin
        found = 1; bs = cs; ca = a; cprv = prv;
      end
      if ((found && !BEST) || mnx(a) == 0 || walks == 64) stop = 1;
      prv = a; a = mnx(a);
    end
    if (found) begin
      if (bs >= ra + 24) begin
        na = ca + 16 + ra;
        push(LSU_INSERT, na, bs - ra - 16, mnx(ca));
        push(LSU_DELETE, cprv, 0, na);
      end else
        push(LSU_DELETE, cprv, 0, mnx(ca));
      ok = 1; ad = ca + 16;
    end
    push(LSU_UNLOCK, 0, 0, 0);
  endtask

  function automatic header_data_req_t got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : '0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // LSU model: random ready, 1..3 cycle response latency, stray responses when idle.
  initial begin
    bit hold_vld = 0, pend = 0;
    int cnt = 0;
    header_data_req_t hold_req;
    header_data_t     rsp_hdr;
    req_lsu_op_e      rsp_op;
    rsp_hdr = '0; rsp_op = LSU_NOP; hold_req = '0;
    forever begin
      @(negedge clk);
      lsu_rsp = '0;
      if (!rst_n) begin
        pend = 0; hold_vld = 0; lsu_ready = 0;
      end else begin
        if (lsu_req.val) saw_val = 1;
        if (hold_vld) chk("lsu_hold", lsu_req, hold_req);
        hold_vld = 0;
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            pend = 0;
            lsu_rsp.val = 1'b1;
            lsu_rsp.header_data = rsp_hdr;
            if (rsp_op == LSU_UNLOCK) unlock_cyc = cyc;
          end
        end else if ($urandom_range(3) == 0) begin
          lsu_rsp.val = 1'b1;
          lsu_rsp.header_data = {$urandom, $urandom, $urandom};
        end
        if (stall_left > 0 && lsu_req.val && lsu_req.lsu_op == LSU_LOCK) begin
          lsu_ready = 0; stall_left--;
        end else
          lsu_ready = ($urandom_range(3) != 0);
        if (lsu_req.val && !lsu_ready) begin
          hold_vld = 1; hold_req = lsu_req;
        end
        if (lsu_req.val && lsu_ready) begin
          got_q.push_back(lsu_req);
          pend = 1; cnt = $urandom_range(1, 3);
          rsp_op = lsu_req.lsu_op;
          rsp_hdr = '0;
          if (rsp_op == LSU_LOAD) begin
            rsp_hdr.addr      = $urandom;
            rsp_hdr.size      = msz(lsu_req.header_data.addr);
            rsp_hdr.next_addr = mnx(lsu_req.header_data.addr);
          end
        end
      end
    end
  end

  task automatic run_req(input string tag, input logic [31:0] sz);
    bit e_ok; logic [31:0] e_addr; int n, t0;
    model(sz, e_ok, e_addr);
    got_q.delete(); saw_val = 0;
    n = 0;
    while (!core_ready && n < 100) begin @(negedge clk); n++; end
    req_valid = 1; req_size = sz; t0 = cyc;
    @(negedge clk);
    req_valid = 0; req_size = $urandom;
    n = 0;
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    last_ok = rsp_ok; last_addr = rsp_addr;
    chk({tag, ":rsp_seen"}, rsp_valid, 1'b1);
    chk({tag, ":ok"}, rsp_ok, e_ok);
    chk({tag, ":addr"}, rsp_addr, e_addr);
    if (exp_q.size() == 0) chk({tag, ":rej_lat"}, cyc - t0, 1);
    else                   chk({tag, ":unlock_lat"}, cyc - unlock_cyc, 1);
    @(negedge clk);
    chk({tag, ":pulse1"}, rsp_valid, 1'b0);
    chk({tag, ":n_lsu"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s:op%0d", tag, i), got_q[i].lsu_op, exp_q[i].lsu_op);
      chk($sformatf("%s:a%0d", tag, i), got_q[i].header_data.addr, exp_q[i].header_data.addr);
      if (exp_q[i].lsu_op != LSU_LOAD && exp_q[i].lsu_op != LSU_DELETE)
        chk($sformatf("%s:s%0d", tag, i), got_q[i].header_data.size, exp_q[i].header_data.size);
      if (exp_q[i].lsu_op != LSU_LOAD)
        chk($sformatf("%s:n%0d", tag, i), got_q[i].header_data.next_addr,
            exp_q[i].header_data.next_addr);
    end
  endtask

  initial begin
    int unsigned l[$];
    int unsigned sz;
    #1;
    repeat (3) @(negedge clk);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_ok", rsp_ok, 1'b0);
    chk("rst_addr", rsp_addr, 32'h0);
    chk("rst_lsu_val", lsu_req.val, 1'b0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_ready", core_ready, 1'b1);

    l = '{256}; build(l);
    run_req("split", 100);
    chk("split:addr_k", last_addr, 32'h110);
    chk("split:ins", got_at(3), {1'b1, LSU_INSERT, 32'h178, 32'd136, 32'h0});
    chk("split:lnk_a", got_at(4).header_data.addr, 32'h10);
    chk("split:lnk_n", got_at(4).header_data.next_addr, 32'h178);

    run_req("nosplit", 240);
    chk("nosplit:addr_k", last_addr, 32'h110);
    chk("nosplit:op3", got_at(3).lsu_op, LSU_DELETE);
    chk("nosplit:lnk_n", got_at(3).header_data.next_addr, 32'h0);

    l = '{32, 64}; build(l);
    run_req("nofit", 128);
    chk("nofit:ok_k", last_ok, 1'b0);
    chk("nofit:unlock", got_at(4).lsu_op, LSU_UNLOCK);

    run_req("zero", 0);
    chk("zero:no_val", saw_val, 1'b0);
    run_req("ovf", 32'hFFFF_FFF9);
    chk("ovf:no_val", saw_val, 1'b0);
    run_req("max_aligned", 32'hFFFF_FFF8);

    l = '{256}; build(l);
    stall_left = 5;
    run_req("stall", 100);
    chk("stall:used", stall_left, 0);

    l = '{200, 48, 64}; build(l);
    run_req("fit_mode", 40);
    chk("fit_mode:addr_k", last_addr, BEST ? 32'h210 : 32'h110);

    l.delete();
    for (int k = 0; k < 70; k++) l.push_back(8);
    build(l);
    run_req("max_walk", 64);

    for (int it = 0; it < 40; it++) begin
      l.delete();
      for (int k = 0; k < $urandom_range(1, 6); k++) l.push_back($urandom_range(0, 64) * 8);
      build(l);
      case ($urandom_range(19))
        0:       sz = 0;
        1:       sz = 32'hFFFF_FFF9 + $urandom_range(0, 6);
        default: sz = $urandom_range(1, 520);
      endcase
      run_req($sformatf("rnd%0d", it), sz);
    end

    // Reset in the middle of a walk: abandoned, no response afterwards.
    l = '{16, 16, 16, 512}; build(l);
    req_valid = 1; req_size = 64;
    @(negedge clk);
    req_valid = 0;
    repeat (8) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_lsu", lsu_req.val, 1'b0);
    @(negedge clk);
    rst_n = 1;
    saw_val = 0;
    begin
      bit seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1;
      end
      chk("mid_rst_nopulse", seen, 1'b0);
    end
    chk("mid_rst_nolsu", saw_val, 1'b0);
    chk("mid_rst_ready", core_ready, 1'b1);
    run_req("post_rst", 64);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fit_alloc_core.md
FIT_ALLOC_CORE -- requirements
Module: fit_alloc_core

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 32: address/size width.
- HEADER_SIZE, 16: header bytes preceding each payload.
- ALIGN_LOG2, 3: payload size alignment (2^ALIGN_LOG2 bytes).
- MIN_SPLIT, 8: minimum remainder payload worth splitting.
- HEAD_ADDR, 'h10: sentinel header address (size 0, next_addr = first free block).
- MAX_WALK, 64: maximum headers loaded per request.
REQ-002 Ports SHALL be:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_alloc_valid_i  in  1  allocation request strobe.
- size_to_allocate_i  in  DATA_W  requested payload bytes.
- core_ready_o  out  1  accepts a request this cycle.
- alloc_rsp_valid_o  out  1  one-cycle result pulse.
- alloc_rsp_ok_o  out  1  1 = success, 0 = failure.
- alloc_addr_o  out  DATA_W  payload address on success, 0 otherwise.
- lsu_ready_i  in  1  LSU accepts request.
- req_to_lsu_o  out  header_data_req_t  val, lsu_op, header_data.
- rsp_from_lsu_i  in  header_data_rsp_t  val, header_data.

Function
REQ-003 A request SHALL be accepted only when req_alloc_valid_i and core_ready_o are both high; core_ready_o SHALL be high only in IDLE.
REQ-004 Aligned size SHALL be req_a = size rounded up to a multiple of 2^ALIGN_LOG2, computed in DATA_W+1 bits.
REQ-005 A size of 0, or a req_a that overflows DATA_W, SHALL be rejected without any LSU traffic: alloc_rsp_valid_o=1 and ok=0 in the cycle after acceptance.
REQ-006 The LSU request SHALL hold val, lsu_op and header_data stable until a cycle with lsu_ready_i=1; the block SHALL then wait for rsp_from_lsu_i.val and ignore rsp_from_lsu_i in all other states.
REQ-007 The state machine SHALL be: IDLE -> LOCK -> LOCK_W -> LOAD -> LOAD_W -> CMP -> {LOAD | INSERT -> INSERT_W | LINK} -> LINK -> LINK_W -> UNLOCK -> UNLOCK_W -> DONE -> IDLE. Each X_W state is the response wait for X.
REQ-008 After LOCK_W, the first LOAD SHALL target HEAD_ADDR; each subsequent LOAD SHALL target the previous header's next_addr.
REQ-009 In CMP, the block SHALL record the loaded header as prev and proceed as follows:
- first-fit: take the first header with size >= req_a.
- not fitting and next_addr==0, or walk count == MAX_WALK: go to UNLOCK with result fail.
REQ-010 On a chosen candidate c with c.size >= req_a+HEADER_SIZE+MIN_SPLIT, the block SHALL INSERT a header {addr=c.addr+HEADER_SIZE+req_a, size=c.size-req_a-HEADER_SIZE, next_addr=c.next_addr}, then LINK with {addr=prev.addr, next_addr=new.addr}.
REQ-011 Otherwise (no split), the block SHALL skip INSERT and LINK with {addr=prev.addr, next_addr=c.next_addr}.
REQ-012 INSERT SHALL use lsu_op INSERT; LINK SHALL use DELETE; LOCK and UNLOCK SHALL carry a zero header.
REQ-013 On success, alloc_addr_o SHALL be c.addr+HEADER_SIZE. The DONE state SHALL pulse alloc_rsp_valid_o for exactly one cycle, one cycle after the UNLOCK response.
REQ-014 Every path that took the lock SHALL issue UNLOCK before DONE.
REQ-015 The walk counter SHALL be $clog2(MAX_WALK+1) bits, cleared on acceptance, and incremented per LOAD response; the sentinel load counts.
REQ-016 The sentinel (size 0) SHALL never be chosen.

Reset
REQ-017 Asserting rst_ni low SHALL immediately force IDLE and zero all registers and all outputs except core_ready_o, which SHALL be 1 after release.
REQ-018 Reset mid-operation SHALL abandon the request with no response pulse; lock recovery is the LSU's responsibility.

Configuration
REQ-019 With ALLOC_BEST_FIT_EN defined, CMP SHALL continue the walk to next_addr==0 or MAX_WALK, retaining the fitting header with the strictly smallest size (earliest wins ties) and its prev. It SHALL then proceed per REQ-010/011, or fail if none fit.
REQ-020 Without ALLOC_BEST_FIT_EN, behaviour SHALL be first-fit per REQ-009.

Structure
REQ-021 header_data_t, header_data_req_t, header_data_rsp_t, req_lsu_op_e and DATA_W SHALL reside in allocator_pkg; the state enum stays local.
REQ-022 Alignment and split arithmetic SHALL be a combinational sub-module fit_alloc_calc (inputs size, c.size, c.addr; outputs req_a, overflow, split, new_addr, new_size).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- List HEAD->0x100(size 256)->0; request 100 -> req_a 104; INSERT {0x178,136,0}; LINK {0x10,0x178}; ok=1, addr 0x110.
- Same list; request 240 -> no split (256<264); no INSERT; LINK {0x10,0}; addr 0x110.
- List 0x100(size 32)->0x200(size 64)->0; request 128 -> two blocks walked, UNLOCK issued, ok=0, addr 0.
- Request size 0 -> ok=0 next cycle; req_to_lsu_o.val never asserts.
- Hold lsu_ready_i=0 for 5 cycles during LOCK -> request held stable; proceeds on ready.
- ALLOC_BEST_FIT_EN; blocks of size 200, 48, 64; request 40 -> 48-byte block chosen.
